// File: rtl/gtp_init_ctrl_pkg.sv
// gtp_init_ctrl_pkg: shared state encoding and timer sizing for the GT init sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gtp_init_ctrl_pkg;

   // Encoding is visible on state_out, so the values are fixed.
   typedef enum logic [2:0] {
      WAIT_PLL = 3'd0,
      TX_RST   = 3'd1,
      TX_WAIT  = 3'd2,
      RX_RST   = 3'd3,
      RX_WAIT  = 3'd4,
      READY    = 3'd5,
      FAIL     = 3'd6
   } state_t;

   localparam int STATE_W = 3;

   // One timer serves every state, so it must hold the largest terminal count.
   function automatic int timer_width(input int pll_timeout,
                                      input int done_timeout,
                                      input int reset_pulse);
      int m;
      m = pll_timeout;
      if (done_timeout > m) m = done_timeout;
      if (reset_pulse > m) m = reset_pulse;
      if (m < 2) return 1;
      return $clog2(m);
   endfunction

   // Width for the default parameter set (125000 cycles -> 17 bits).
   localparam int TIMER_W = timer_width(125000, 125000, 16);

endpackage

// File: rtl/gtp_sync2.sv
// gtp_sync2: two-flop synchronizer for a single asynchronous level.
// Latency: 2 cycles from input change to q.
// Backpressure: none.
// Ports: clk (sampling clock), rst (sync active-high, clears both flops), d (async level), q (synchronized level).
module gtp_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/gtp_init_ctrl.sv
// gtp_init_ctrl: GT transceiver bring-up sequencer (PLL lock, TX reset, RX reset, retry/fail).
// Latency: status inputs take 2 cycles through synchronizers, the FSM reacts on the next edge; all outputs registered.
// Backpressure: none; rx_restart is a single-cycle request honoured only in READY.
// Ports: drpclk_in/soft_reset (clock, sync active-high reset); gt_pll_locked, gt_txresetdone,
//        gt_rxresetdone (async GT status); rx_restart (datapath RX re-reset request);
//        gt_txreset, gt_rxreset, gt_txusrrdy, gt_rxusrrdy (GT controls); link_ready, init_fail,
//        retry_cnt, state_out (status).
module gtp_init_ctrl
   import gtp_init_ctrl_pkg::*;
#(
   parameter int RESET_PULSE  = 16,
   parameter int PLL_TIMEOUT  = 125000,
   parameter int DONE_TIMEOUT = 125000,
   parameter int MAX_RETRY    = 3
) (
   input  logic               drpclk_in,
   input  logic               soft_reset,
   input  logic               gt_pll_locked,
   input  logic               gt_txresetdone,
   input  logic               gt_rxresetdone,
   input  logic               rx_restart,
   output logic               gt_txreset,
   output logic               gt_rxreset,
   output logic               gt_txusrrdy,
   output logic               gt_rxusrrdy,
   output logic               link_ready,
   output logic               init_fail,
   output logic [1:0]         retry_cnt,
   output logic [STATE_W-1:0] state_out
);

   localparam int TW = timer_width(PLL_TIMEOUT, DONE_TIMEOUT, RESET_PULSE);

   // Terminal counts: the timer is 0 on the first cycle in a state.
   localparam logic [TW-1:0] PLL_LAST   = TW'(PLL_TIMEOUT - 1);
   localparam logic [TW-1:0] DONE_LAST  = TW'(DONE_TIMEOUT - 1);
   localparam logic [TW-1:0] PULSE_LAST = TW'(RESET_PULSE - 1);
   localparam logic [1:0]    RETRY_MAX  = 2'(MAX_RETRY);

   logic lock_s, txdone_s, rxdone_s;

   gtp_sync2 u_sync_lock   (.clk(drpclk_in), .rst(soft_reset), .d(gt_pll_locked),  .q(lock_s));
   gtp_sync2 u_sync_txdone (.clk(drpclk_in), .rst(soft_reset), .d(gt_txresetdone), .q(txdone_s));
   gtp_sync2 u_sync_rxdone (.clk(drpclk_in), .rst(soft_reset), .d(gt_rxresetdone), .q(rxdone_s));

   state_t        state, next_state;
   logic [TW-1:0] timer;
   logic          fail_evt;
   logic          tmr_clr;
   logic          txrst_d, rxrst_d, txusr_d, rxusr_d, ready_d, fail_d;

   // Next state. Every failure funnels through fail_evt so the retry
   // decision lives in one place below the case.
   always_comb begin
      next_state = state;
      fail_evt   = 1'b0;
      case (state)
         WAIT_PLL: begin
            if (lock_s)                 next_state = TX_RST;
            else if (timer == PLL_LAST) fail_evt   = 1'b1;
         end
         TX_RST: begin
            if (!lock_s)                  fail_evt   = 1'b1;
            else if (timer == PULSE_LAST) next_state = TX_WAIT;
         end
         TX_WAIT: begin
            if (!lock_s)                 fail_evt   = 1'b1;
            else if (txdone_s)           next_state = RX_RST;
            else if (timer == DONE_LAST) fail_evt   = 1'b1;
         end
         RX_RST: begin
            if (!lock_s)                  fail_evt   = 1'b1;
            else if (timer == PULSE_LAST) next_state = RX_WAIT;
         end
         RX_WAIT: begin
            if (!lock_s)                 fail_evt   = 1'b1;
            else if (rxdone_s)           next_state = READY;
            else if (timer == DONE_LAST) fail_evt   = 1'b1;
         end
         READY: begin
            // Lock loss outranks any RX-only event: TX must be re-initialised too.
            if (!lock_s)                       next_state = WAIT_PLL;
            else if (!rxdone_s || rx_restart)  next_state = RX_RST;
         end
         FAIL:    next_state = FAIL;
         default: next_state = WAIT_PLL;
      endcase

      if (fail_evt) next_state = (retry_cnt >= RETRY_MAX) ? FAIL : WAIT_PLL;

      // A retry re-enters WAIT_PLL from WAIT_PLL, which must still restart the timer.
      tmr_clr = fail_evt || (next_state != state);
   end

   // Output decode from next_state so the registered outputs line up with state.
   // RX reset is released during the TX phase so it appears as a clean pulse in RX_RST.
   always_comb begin
      txrst_d = 1'b0;
      rxrst_d = 1'b0;
      txusr_d = 1'b0;
      rxusr_d = 1'b0;
      ready_d = 1'b0;
      fail_d  = 1'b0;
      case (next_state)
         WAIT_PLL: begin txrst_d = 1'b1; rxrst_d = 1'b1; end
         TX_RST:   txrst_d = 1'b1;
         TX_WAIT:  txusr_d = 1'b1;
         RX_RST:   begin rxrst_d = 1'b1; txusr_d = 1'b1; end
         RX_WAIT:  begin txusr_d = 1'b1; rxusr_d = 1'b1; end
         READY:    begin txusr_d = 1'b1; rxusr_d = 1'b1; ready_d = 1'b1; end
         FAIL:     begin txrst_d = 1'b1; rxrst_d = 1'b1; fail_d = 1'b1; end
         default:  begin txrst_d = 1'b1; rxrst_d = 1'b1; end
      endcase
   end

   always_ff @(posedge drpclk_in) begin
      if (soft_reset) begin
         state       <= WAIT_PLL;
         timer       <= '0;
         retry_cnt   <= '0;
         gt_txreset  <= 1'b1;
         gt_rxreset  <= 1'b1;
         gt_txusrrdy <= 1'b0;
         gt_rxusrrdy <= 1'b0;
         link_ready  <= 1'b0;
         init_fail   <= 1'b0;
      end else begin
         state <= next_state;
         timer <= tmr_clr ? '0 : timer + 1'b1;

         // Retry history is forgotten once a link has been brought up.
         if (next_state == READY && state != READY)
            retry_cnt <= '0;
         else if (fail_evt && retry_cnt < RETRY_MAX)
            retry_cnt <= retry_cnt + 1'b1;

         gt_txreset  <= txrst_d;
         gt_rxreset  <= rxrst_d;
         gt_txusrrdy <= txusr_d;
         gt_rxusrrdy <= rxusr_d;
         link_ready  <= ready_d;
         init_fail   <= fail_d;
      end
   end

   assign state_out = state;

endmodule

// File: tb/tb_gtp_init_ctrl.sv
// tb_gtp_init_ctrl: directed bench for gtp_init_ctrl with a small GT reset-done model.
// Latency: n/a.
// Backpressure: n/a.
module tb_gtp_init_ctrl;

   logic       clk = 1'b0;
   logic       soft_reset = 1'b1;
   logic       lock_drv = 1'b0;
   logic       txdone = 1'b0;
   logic       rxdone = 1'b0;
   logic       rx_restart = 1'b0;
   logic       gt_txreset, gt_rxreset, gt_txusrrdy, gt_rxusrrdy, link_ready, init_fail;
   logic [1:0] retry_cnt;
   logic [2:0] state_out;
   logic [10:0] obs;

   int n_cmp = 0;
   int n_bad = 0;
   int tx_cnt = 0;
   int rx_cnt = 0;

   // obs = {state, txreset, rxreset, txusrrdy, rxusrrdy, link_ready, init_fail, retry_cnt}
   localparam logic [10:0] E_WAIT0  = {3'd0, 6'b110000, 2'd0};
   localparam logic [10:0] E_WAIT1  = {3'd0, 6'b110000, 2'd1};
   localparam logic [10:0] E_WAIT2  = {3'd0, 6'b110000, 2'd2};
   localparam logic [10:0] E_WAIT3  = {3'd0, 6'b110000, 2'd3};
   localparam logic [10:0] E_TXRST0 = {3'd1, 6'b100000, 2'd0};
   localparam logic [10:0] E_TXW1   = {3'd2, 6'b001000, 2'd1};
   localparam logic [10:0] E_TXW2   = {3'd2, 6'b001000, 2'd2};
   localparam logic [10:0] E_RXRST0 = {3'd3, 6'b011000, 2'd0};
   localparam logic [10:0] E_READY  = {3'd5, 6'b001110, 2'd0};
   localparam logic [10:0] E_FAIL   = {3'd6, 6'b110001, 2'd3};

   always #5 clk = ~clk;

   assign obs = {state_out, gt_txreset, gt_rxreset, gt_txusrrdy, gt_rxusrrdy,
                 link_ready, init_fail, retry_cnt};

   gtp_init_ctrl #(
      .RESET_PULSE (4),
      .PLL_TIMEOUT (100),
      .DONE_TIMEOUT(100),
      .MAX_RETRY   (3)
   ) dut (
      .drpclk_in     (clk),
      .soft_reset    (soft_reset),
      .gt_pll_locked (lock_drv),
      .gt_txresetdone(txdone),
      .gt_rxresetdone(rxdone),
      .rx_restart    (rx_restart),
      .gt_txreset    (gt_txreset),
      .gt_rxreset    (gt_rxreset),
      .gt_txusrrdy   (gt_txusrrdy),
      .gt_rxusrrdy   (gt_rxusrrdy),
      .link_ready    (link_ready),
      .init_fail     (init_fail),
      .retry_cnt     (retry_cnt),
      .state_out     (state_out)
   );

   // One clock; then the GT model: resetdone drops while its reset is high
   // and rises 20 cycles after the reset is released.
   task automatic step();
      @(posedge clk);
      #1;
      if (gt_txreset) begin tx_cnt = 0; txdone = 1'b0; end
      else begin if (tx_cnt < 20) tx_cnt++; if (tx_cnt == 20) txdone = 1'b1; end
      if (gt_rxreset) begin rx_cnt = 0; rxdone = 1'b0; end
      else begin if (rx_cnt < 20) rx_cnt++; if (rx_cnt == 20) rxdone = 1'b1; end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      soft_reset = 1'b1;
      rx_restart = 1'b0;
      step();
      soft_reset = 1'b0;
   endtask

   // Runs until link_ready, counting reset/usrrdy activity outside WAIT_PLL.
   task automatic run_to_ready(input int budget, output int tx_hi, output int rx_hi,
                               output int txu_lo, output bit ok);
      tx_hi = 0; rx_hi = 0; txu_lo = 0; ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (link_ready === 1'b1) begin ok = 1'b1; break; end
         if (state_out != 3'd0) begin
            if (gt_txreset)   tx_hi++;
            if (gt_rxreset)   rx_hi++;
            if (!gt_txusrrdy) txu_lo++;
         end
         step();
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (state_out === s) begin ok = 1'b1; break; end
         step();
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (obs !== E_WAIT0) begin n_bad++; $display("FAIL reset_state: got %b want %b", obs, E_WAIT0); end
   endtask

   task automatic test_bringup();
      int tx_hi, rx_hi, txu_lo; bit ok;
      do_reset();
      lock_drv = 1'b0;
      steps(10);
      lock_drv = 1'b1;
      steps(2);
      n_cmp++; if (obs !== E_WAIT0) begin n_bad++; $display("FAIL bringup_sync_delay: got %b want %b", obs, E_WAIT0); end
      step();
      n_cmp++; if (obs !== E_TXRST0) begin n_bad++; $display("FAIL bringup_tx_rst: got %b want %b", obs, E_TXRST0); end
      run_to_ready(200, tx_hi, rx_hi, txu_lo, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bringup_reach_ready: got %0d want 1", ok); end
      n_cmp++; if (tx_hi !== 4) begin n_bad++; $display("FAIL bringup_tx_pulse: got %0d want 4", tx_hi); end
      n_cmp++; if (rx_hi !== 4) begin n_bad++; $display("FAIL bringup_rx_pulse: got %0d want 4", rx_hi); end
      n_cmp++; if (txu_lo !== 4) begin n_bad++; $display("FAIL bringup_txusr_low: got %0d want 4", txu_lo); end
      n_cmp++; if (obs !== E_READY) begin n_bad++; $display("FAIL bringup_ready: got %b want %b", obs, E_READY); end
   endtask

   task automatic test_lock_loss();
      int tx_hi, rx_hi, txu_lo; bit ok;
      lock_drv = 1'b0;
      steps(2);
      n_cmp++; if (obs !== E_READY) begin n_bad++; $display("FAIL lockloss_hold: got %b want %b", obs, E_READY); end
      step();
      n_cmp++; if (obs !== E_WAIT0) begin n_bad++; $display("FAIL lockloss_wait_pll: got %b want %b", obs, E_WAIT0); end
      steps(7);
      lock_drv = 1'b1;
      run_to_ready(300, tx_hi, rx_hi, txu_lo, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL lockloss_reach_ready: got %0d want 1", ok); end
      n_cmp++; if (tx_hi !== 4) begin n_bad++; $display("FAIL lockloss_tx_pulse: got %0d want 4", tx_hi); end
      n_cmp++; if (rx_hi !== 4) begin n_bad++; $display("FAIL lockloss_rx_pulse: got %0d want 4", rx_hi); end
   endtask

   task automatic test_rx_restart();
      int tx_hi, rx_hi, txu_lo; bit ok;
      rx_restart = 1'b1;
      step();
      rx_restart = 1'b0;
      n_cmp++; if (obs !== E_RXRST0) begin n_bad++; $display("FAIL rxrestart_rx_rst: got %b want %b", obs, E_RXRST0); end
      run_to_ready(200, tx_hi, rx_hi, txu_lo, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rxrestart_reach_ready: got %0d want 1", ok); end
      n_cmp++; if (tx_hi !== 0) begin n_bad++; $display("FAIL rxrestart_tx_pulse: got %0d want 0", tx_hi); end
      n_cmp++; if (rx_hi !== 4) begin n_bad++; $display("FAIL rxrestart_rx_pulse: got %0d want 4", rx_hi); end
      n_cmp++; if (txu_lo !== 0) begin n_bad++; $display("FAIL rxrestart_txusr_low: got %0d want 0", txu_lo); end
      n_cmp++; if (obs !== E_READY) begin n_bad++; $display("FAIL rxrestart_ready: got %b want %b", obs, E_READY); end
   endtask

   // Lock loss reaches the FSM 3 edges after the pin; rx_restart is timed to land on that edge.
   task automatic test_same_cycle();
      int tx_hi, rx_hi, txu_lo; bit ok;
      lock_drv = 1'b0;
      steps(2);
      rx_restart = 1'b1;
      step();
      rx_restart = 1'b0;
      n_cmp++; if (obs !== E_WAIT0) begin n_bad++; $display("FAIL samecycle_wait_pll: got %b want %b", obs, E_WAIT0); end
      lock_drv = 1'b1;
      run_to_ready(300, tx_hi, rx_hi, txu_lo, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL samecycle_reach_ready: got %0d want 1", ok); end
   endtask

   task automatic test_timeout_fail();
      lock_drv = 1'b0;
      do_reset();
      n_cmp++; if (obs !== E_WAIT0) begin n_bad++; $display("FAIL softreset_from_ready: got %b want %b", obs, E_WAIT0); end
      steps(99);
      n_cmp++; if (obs !== E_WAIT0) begin n_bad++; $display("FAIL timeout_before_first: got %b want %b", obs, E_WAIT0); end
      step();
      n_cmp++; if (obs !== E_WAIT1) begin n_bad++; $display("FAIL timeout_retry1: got %b want %b", obs, E_WAIT1); end
      steps(100);
      n_cmp++; if (obs !== E_WAIT2) begin n_bad++; $display("FAIL timeout_retry2: got %b want %b", obs, E_WAIT2); end
      steps(100);
      n_cmp++; if (obs !== E_WAIT3) begin n_bad++; $display("FAIL timeout_retry3: got %b want %b", obs, E_WAIT3); end
      steps(99);
      n_cmp++; if (obs !== E_WAIT3) begin n_bad++; $display("FAIL timeout_before_fail: got %b want %b", obs, E_WAIT3); end
      step();
      n_cmp++; if (obs !== E_FAIL) begin n_bad++; $display("FAIL timeout_fail_state: got %b want %b", obs, E_FAIL); end
      steps(50);
      lock_drv = 1'b1;
      steps(10);
      n_cmp++; if (obs !== E_FAIL) begin n_bad++; $display("FAIL fail_sticky: got %b want %b", obs, E_FAIL); end
      do_reset();
      n_cmp++; if (obs !== E_WAIT0) begin n_bad++; $display("FAIL softreset_from_fail: got %b want %b", obs, E_WAIT0); end
   endtask

   task automatic test_retry_clear();
      int tx_hi, rx_hi, txu_lo; bit ok;
      lock_drv = 1'b0;
      do_reset();
      steps(100);
      n_cmp++; if (retry_cnt !== 2'd1) begin n_bad++; $display("FAIL retryclr_count: got %0d want 1", retry_cnt); end
      lock_drv = 1'b1;
      run_to_ready(300, tx_hi, rx_hi, txu_lo, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL retryclr_reach_ready: got %0d want 1", ok); end
      n_cmp++; if (obs !== E_READY) begin n_bad++; $display("FAIL retryclr_ready: got %b want %b", obs, E_READY); end
   endtask

   task automatic test_soft_reset_tx_wait();
      bit ok;
      lock_drv = 1'b0;
      do_reset();
      steps(100);
      lock_drv = 1'b1;
      wait_state(3'd2, 60, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL txwait_reach1: got %0d want 1", ok); end
      n_cmp++; if (obs !== E_TXW1) begin n_bad++; $display("FAIL txwait_retry1: got %b want %b", obs, E_TXW1); end
      lock_drv = 1'b0;
      steps(2);
      n_cmp++; if (state_out !== 3'd2) begin n_bad++; $display("FAIL lockdrop_hold: got %0d want 2", state_out); end
      step();
      n_cmp++; if (obs !== E_WAIT2) begin n_bad++; $display("FAIL lockdrop_failure: got %b want %b", obs, E_WAIT2); end
      lock_drv = 1'b1;
      wait_state(3'd2, 60, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL txwait_reach2: got %0d want 1", ok); end
      rx_restart = 1'b1;
      step();
      rx_restart = 1'b0;
      n_cmp++; if (obs !== E_TXW2) begin n_bad++; $display("FAIL rxrestart_ignored: got %b want %b", obs, E_TXW2); end
      soft_reset = 1'b1;
      step();
      soft_reset = 1'b0;
      n_cmp++; if (obs !== E_WAIT0) begin n_bad++; $display("FAIL softreset_tx_wait: got %b want %b", obs, E_WAIT0); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_bringup();
      test_lock_loss();
      test_rx_restart();
      test_same_cycle();
      test_timeout_fail();
      test_retry_clear();
      test_soft_reset_tx_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gtp_init_ctrl.md
GTP_INIT_CTRL -- requirements
Module: gtp_init_ctrl

Interface
REQ-001 SHALL have parameter RESET_PULSE, default 16: cycles each GT reset is held asserted.
REQ-002 SHALL have parameter PLL_TIMEOUT, default 125000: cycles allowed for PLL lock (1 ms at 125 MHz).
REQ-003 SHALL have parameter DONE_TIMEOUT, default 125000: cycles allowed for tx/rx resetdone.
REQ-004 SHALL have parameter MAX_RETRY, default 3: failed attempts allowed before the FAIL state.
REQ-005 SHALL have port drpclk_in, input, 1: sole clock; one clock, reset is synchronous and active-high.
REQ-006 SHALL have port soft_reset, input, 1: synchronous active-high reset.
REQ-007 SHALL have port gt_pll_locked, input, 1: PLL lock from the transceiver; asynchronous.
REQ-008 SHALL have port gt_txresetdone, input, 1: TX reset done; asynchronous.
REQ-009 SHALL have port gt_rxresetdone, input, 1: RX reset done; asynchronous.
REQ-010 SHALL have port rx_restart, input, 1: single-cycle request from the datapath to re-reset RX only.
REQ-011 SHALL have port gt_txreset, output, 1: drives the transceiver TX reset.
REQ-012 SHALL have port gt_rxreset, output, 1: drives the transceiver RX reset.
REQ-013 SHALL have port gt_txusrrdy, output, 1: TX user-ready.
REQ-014 SHALL have port gt_rxusrrdy, output, 1: RX user-ready.
REQ-015 SHALL have port link_ready, output, 1: high only in the READY state.
REQ-016 SHALL have port init_fail, output, 1: high only in the FAIL state.
REQ-017 SHALL have port retry_cnt, output, 2: count of failed attempts.
REQ-018 SHALL have port state_out, output, 3: encoding of the current state.

Function
REQ-019 SHALL pass gt_pll_locked, gt_txresetdone and gt_rxresetdone each through a 2-flop synchronizer; all decisions use the synchronized values (2-cycle input latency).
REQ-020 SHALL implement the states WAIT_PLL, TX_RST, TX_WAIT, RX_RST, RX_WAIT, READY and FAIL, with a single timer that clears on every state entry.
REQ-021 In WAIT_PLL, gt_txreset=gt_rxreset=1 and both usrrdy=0; advance to TX_RST when lock=1; on timer==PLL_TIMEOUT-1, register a failure.
REQ-022 In TX_RST, gt_txreset=1 for exactly RESET_PULSE cycles, then go to TX_WAIT.
REQ-023 In TX_WAIT, gt_txreset=0 and gt_txusrrdy=1; go to RX_RST on txresetdone=1; on timer==DONE_TIMEOUT-1, register a failure.
REQ-024 RX_RST and RX_WAIT SHALL mirror TX_RST and TX_WAIT using the rx signals; gt_txusrrdy stays 1 throughout; RX_WAIT goes to READY on rxresetdone=1.
REQ-025 In READY, gt_txusrrdy, gt_rxusrrdy and link_ready SHALL all be 1.
REQ-026 From READY, lock=0 SHALL go to WAIT_PLL (full re-init); otherwise rxresetdone=0 or rx_restart=1 SHALL go to RX_RST.
REQ-027 When lock loss and an RX event occur in the same cycle, lock loss SHALL win.
REQ-028 A lock drop during TX_RST through RX_WAIT SHALL register a failure.
REQ-029 A failure with retry_cnt<MAX_RETRY SHALL increment retry_cnt and go to WAIT_PLL; with retry_cnt==MAX_RETRY it SHALL go to FAIL without incrementing.
REQ-030 retry_cnt SHALL saturate and SHALL clear only on soft_reset or on entry to READY.
REQ-031 In FAIL, both resets SHALL be held at 1 and both usrrdy at 0; FAIL exits only on soft_reset.
REQ-032 rx_restart outside READY SHALL be ignored.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 soft_reset SHALL take effect on the next clock edge.
REQ-035 On reset: state=WAIT_PLL, timer=0, retry_cnt=0, gt_txreset=1, gt_rxreset=1, usrrdy=0, link_ready=0, init_fail=0, synchronizers=0.
REQ-036 soft_reset asserted mid-sequence, including in READY or FAIL, SHALL abort the sequence and restart from WAIT_PLL.

Structure
REQ-037 A shared package SHALL hold the state encoding constants (WAIT_PLL=0 through FAIL=6) and the timer width, derived as clog2 of the maximum of PLL_TIMEOUT, DONE_TIMEOUT and RESET_PULSE.
REQ-038 The 2-flop synchronizer SHALL be a sub-module, gtp_sync2, instantiated three times.

Verification
REQ-039 Scenario (RESET_PULSE=4, timeouts=100): lock at cycle 10, txresetdone 20 cycles after gt_txreset falls, rxresetdone 20 cycles after gt_rxreset falls -> each reset pulse is exactly 4 cycles, link_ready=1, retry_cnt=0.
REQ-040 Scenario: lock never asserted -> 4 timeouts of 100 cycles, retry_cnt reaches 3, init_fail=1 and gt_txreset=1 thereafter.
REQ-041 Scenario: in READY, drop lock for 10 cycles -> link_ready falls 3 cycles later, state=WAIT_PLL, full TX then RX sequence re-runs.
REQ-042 Scenario: in READY, pulse rx_restart -> only gt_rxreset pulses (4 cycles), gt_txusrrdy stays 1, READY returns.
REQ-043 Scenario: in READY, lock drop and rx_restart in the same cycle -> WAIT_PLL taken.
REQ-044 Scenario: soft_reset in TX_WAIT with retry_cnt=2 -> next cycle state=WAIT_PLL, retry_cnt=0, both resets=1.
